// File: rtl/mmu_seq_control.sv
// mmu_seq_control: tile sequencer for the systolic matrix unit.
// For each tile it loads weights, fires the input read wavefront and waits
// for the output drain handshake, then pulses done at the end of the job.
// Optional build macro SEQ_PERF_EN adds a saturating busy_cycles counter.
// Outputs are registered from next-state values so they line up with state.
module mmu_seq_control #(
  parameter int unsigned width_height = 16,
  parameter int unsigned tile_width   = 8,
  localparam int unsigned row_width   = $clog2(width_height)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [tile_width-1:0]         num_tiles,
  input  logic                          wr_done,
  output logic                          busy,
  output logic                          done,
  output logic                          weight_en,
  output logic [tile_width+row_width-1:0] weight_addr,
  output logic                          rd_active,
`ifdef SEQ_PERF_EN
  output logic [31:0]                   busy_cycles,
`endif
  output logic [tile_width-1:0]         tile_idx
);

  localparam int unsigned phase_width = $clog2(2 * width_height) + 1;
  localparam int unsigned addr_width  = tile_width + row_width;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN,
    NEXT,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [phase_width-1:0]  phase, phase_n;
  logic [tile_width-1:0]   ntiles, ntiles_n;
  logic [tile_width-1:0]   tile_n;
  logic                    wr_latch, latch_n;
  logic                    busy_n, done_n, weight_en_n, rd_active_n;
  logic [addr_width-1:0]   weight_addr_n;

  // Next-state, counter and output decode.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    tile_n   = tile_idx;
    ntiles_n = ntiles;
    latch_n  = wr_latch;

    // A drain handshake that arrives before DRAIN is remembered.
    if (wr_done && (state != IDLE) && (state != DRAIN)) begin
      latch_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          ntiles_n = num_tiles;
          tile_n   = '0;
          phase_n  = '0;
          state_n  = (num_tiles != '0) ? LOAD_W : DONE;
        end
      end
      LOAD_W: begin
        if (phase == phase_width'(width_height - 1)) begin
          phase_n = '0;
          state_n = COMPUTE;
        end else begin
          phase_n = phase + phase_width'(1);
        end
      end
      COMPUTE: begin
        if (phase == phase_width'(2 * width_height - 1)) begin
          phase_n = '0;
          state_n = DRAIN;
        end else begin
          phase_n = phase + phase_width'(1);
        end
      end
      DRAIN: begin
        if (wr_done || wr_latch) begin
          latch_n = 1'b0;
          state_n = NEXT;
        end
      end
      NEXT: begin
        if (tile_idx == ntiles - tile_width'(1)) begin
          state_n = DONE;
        end else begin
          tile_n  = tile_idx + tile_width'(1);
          phase_n = '0;
          state_n = LOAD_W;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n        = (state_n != IDLE);
    done_n        = (state_n == DONE);
    weight_en_n   = (state_n == LOAD_W);
    weight_addr_n = weight_en_n ? {tile_n, phase_n[row_width-1:0]} : '0;
    rd_active_n   = (state_n == COMPUTE) && (state != COMPUTE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      ntiles      <= '0;
      tile_idx    <= '0;
      wr_latch    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      weight_en   <= 1'b0;
      weight_addr <= '0;
      rd_active   <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      ntiles      <= ntiles_n;
      tile_idx    <= tile_n;
      wr_latch    <= latch_n;
      busy        <= busy_n;
      done        <= done_n;
      weight_en   <= weight_en_n;
      weight_addr <= weight_addr_n;
      rd_active   <= rd_active_n;
    end
  end

`ifdef SEQ_PERF_EN
  // Saturating count of busy cycles, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      busy_cycles <= '0;
    end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmu_seq_control.sv
// Directed bench for mmu_seq_control with width_height=4.
// Cycle c is the clock period that follows sampling edge c-1; start is
// sampled at edge 0, so the first busy cycle is cycle 1.
module tb_mmu_seq_control;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_tiles;
  logic        wr_done;
  logic        busy;
  logic        done;
  logic        weight_en;
  logic [9:0]  weight_addr;
  logic        rd_active;
  logic [7:0]  tile_idx;
`ifdef SEQ_PERF_EN
  logic [31:0] busy_cycles;
`endif

  int total;
  int bad;

  logic [21:0] obs;
  assign obs = {busy, done, weight_en, rd_active, weight_addr, tile_idx};

  mmu_seq_control #(
    .width_height(4),
    .tile_width  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_tiles  (num_tiles),
    .wr_done    (wr_done),
    .busy       (busy),
    .done       (done),
    .weight_en  (weight_en),
    .weight_addr(weight_addr),
    .rd_active  (rd_active),
`ifdef SEQ_PERF_EN
    .busy_cycles(busy_cycles),
`endif
    .tile_idx   (tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 22'd0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=%h", obs, 22'd0);
    end
    reset = 1'b0;
    tick();
    total++;
    if (obs !== 22'd0) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 22'd0);
    end
  endtask

  task automatic test_single_tile();
    logic eb, ed, ew, er;
    logic [9:0]  ea;
    logic [21:0] exp;
    num_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      wr_done = (c == 15);
      ew = (c <= 4);
      ea = ew ? 10'(c - 1) : 10'd0;
      er = (c == 5);
      eb = (c <= 17);
      ed = (c == 17);
      exp = {eb, ed, ew, er, ea, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single c=%0d got=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    wr_done = 1'b0;
  endtask

  task automatic test_three_tiles();
    logic eb, ed, ew, er;
    logic [9:0]  ea;
    logic [7:0]  et;
    logic [21:0] exp;
    int t, r, rd_cnt, done_cnt;
    rd_cnt = 0;
    done_cnt = 0;
    num_tiles = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      t = (c - 1) / 16;
      r = (c - 1) % 16;
      if (c <= 48) begin
        wr_done = (r == 14);
        ew = (r < 4);
        ea = ew ? 10'(t * 4 + r) : 10'd0;
        er = (r == 4);
        eb = 1'b1;
        ed = 1'b0;
        et = 8'(t);
      end else begin
        wr_done = 1'b0;
        ew = 1'b0;
        ea = 10'd0;
        er = 1'b0;
        eb = (c == 49);
        ed = (c == 49);
        et = 8'd2;
      end
      exp = {eb, ed, ew, er, ea, et};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL three c=%0d got=%h exp=%h", c, obs, exp);
      end
      rd_cnt += int'(rd_active);
      done_cnt += int'(done);
      tick();
    end
    wr_done = 1'b0;
    total++;
    if (rd_cnt != 3) begin
      bad++;
      $display("FAIL three_rd_pulses got=%0d exp=3", rd_cnt);
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL three_done_pulses got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_early_wr_done();
    logic eb, ed, ew, er;
    logic [9:0]  ea;
    logic [21:0] exp;
    num_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      wr_done = (c == 8);
      ew = (c <= 4);
      ea = ew ? 10'(c - 1) : 10'd0;
      er = (c == 5);
      eb = (c <= 15);
      ed = (c == 15);
      exp = {eb, ed, ew, er, ea, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL early c=%0d got=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    wr_done = 1'b0;
  endtask

  task automatic test_zero_tiles();
    logic [21:0] exp;
    num_tiles = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      exp = (c == 1) ? {1'b1, 1'b1, 20'd0} : 22'd0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL zero c=%0d got=%h exp=%h", c, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_ignored_start_and_reset();
    logic eb, ed, ew, er;
    logic [9:0]  ea;
    logic [21:0] exp;
    // Restart during COMPUTE with a different count must not alter the job.
    num_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      start = (c == 7);
      num_tiles = (c == 7) ? 8'd3 : 8'd1;
      wr_done = (c == 15);
      ew = (c <= 4);
      ea = ew ? 10'(c - 1) : 10'd0;
      er = (c == 5);
      eb = (c <= 17);
      ed = (c == 17);
      exp = {eb, ed, ew, er, ea, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL ign_start c=%0d got=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    start = 1'b0;
    wr_done = 1'b0;
    // Reset while in DRAIN.
    num_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) tick();
    total++;
    if (obs !== {1'b1, 21'd0}) begin
      bad++;
      $display("FAIL pre_reset_drain got=%h exp=%h", obs, {1'b1, 21'd0});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (obs !== 22'd0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", obs, 22'd0);
    end
    // Stray wr_done in IDLE must be dropped.
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (obs !== 22'd0) begin
        bad++;
        $display("FAIL stray_idle c=%0d got=%h exp=%h", c, obs, 22'd0);
      end
      tick();
    end
    // A fresh job must still wait in DRAIN for its own handshake.
    num_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      wr_done = (c == 15);
      ew = (c <= 4);
      ea = ew ? 10'(c - 1) : 10'd0;
      er = (c == 5);
      eb = (c <= 17);
      ed = (c == 17);
      exp = {eb, ed, ew, er, ea, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL after_stray c=%0d got=%h exp=%h", c, obs, exp);
      end
      tick();
    end
    wr_done = 1'b0;
  endtask

`ifdef SEQ_PERF_EN
  task automatic test_perf();
    num_tiles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      wr_done = (c == 15);
      tick();
    end
    wr_done = 1'b0;
    total++;
    if (busy_cycles !== 32'd17) begin
      bad++;
      $display("FAIL perf_count got=%0d exp=17", busy_cycles);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy_cycles !== 32'd0) begin
      bad++;
      $display("FAIL perf_clear got=%0d exp=0", busy_cycles);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    num_tiles = 8'd0;
    wr_done = 1'b0;
    test_reset();
    test_single_tile();
    test_three_tiles();
    test_early_wr_done();
    test_zero_tiles();
    test_ignored_start_and_reset();
`ifdef SEQ_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
